light_sequencer: RTL
====================

Name: light_sequencer

Overview:
- Controller side of the light-counter interface.
- Runs the GREEN -> YELLOW -> RED -> GREEN phase machine for one approach and drives the lamp outputs.
- Drives the counter's one-hot `init` load strobe and its `en` decrement strobe, and consumes the counter's `last` flag and count value.
- Sits between the 1 Hz tick generator and the light-counter instance in the intersection top level.

Parameters:
- pINIT_WIDTH, 3: width of `init` one-hot. Bit 0 = green, bit 1 = yellow, bit 2 = red.
- pCNT_WIDTH, 5: width of `cnt_in`. Must match the counter's count width.
- pGREEN_INIT_VAL, 14: green reload value. Must match the counter; used for elapsed-green arithmetic.
- pPED_MIN_GREEN, 4: minimum elapsed green ticks before a pedestrian cut is allowed. Used only with PED_REQ_EN.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset: synchronous, active-low.
- tick  input  1  one-cycle timebase strobe.
- hold  input  1  manual hold: freezes the phase and suppresses `en`.
- last  input  1  counter at zero, from the counter.
- cnt_in  input  pCNT_WIDTH  counter value, from the counter.
- init  output  pINIT_WIDTH  one-hot load strobe to the counter.
- en  output  1  decrement strobe to the counter.
- light  output  3  lamp drive, one-hot {red, yellow, green}.
- ped_req  input  1  pedestrian request. Present only with PED_REQ_EN.
- walk  output  1  walk lamp. Present only with PED_REQ_EN.

Behaviour:
- States: G_LD, GREEN, Y_LD, YELLOW, R_LD, RED. State register is binary; all outputs are Moore decodes of registered state, except `en`.
- Reset (rst_n=0 at a clk edge): state <= G_LD, walk <= 0, ped_pend <= 0. While in G_LD: init=3'b001, light=3'b001, en=0.
- Load states (x_LD):
  - Exactly one cycle, then an unconditional move to the matching dwell state. `hold` and `tick` are ignored here.
  - init = one-hot of the phase: G_LD=001, Y_LD=010, R_LD=100.
  - init=000 in every other state.
- Dwell states (GREEN, YELLOW, RED):
  - en = tick & ~last & ~hold (combinational). `en` is never asserted with last=1, so the counter never wraps through 0.
  - Transition when tick & last & ~hold: GREEN->Y_LD, YELLOW->R_LD, RED->G_LD.
  - The `last` value seen during a load-state cycle is stale and is ignored by construction, since load states do not evaluate `last`.
- light:
  - G_LD/GREEN = 001, Y_LD/YELLOW = 010, R_LD/RED = 100.
  - Never zero and never multi-hot after reset.
- Phase length with a tick every cycle is (INIT_VAL + 2) cycles: 1 load + INIT_VAL decrements + 1 zero cycle. With counter defaults 14/2/17 this gives 16/4/19 cycles, a 39-cycle period.
- hold:
  - Phase and count freeze.
  - On hold release, a pending zero transitions on the next tick.
- Simultaneous tick & last & hold: hold wins, no transition.
- Reset mid-phase: returns to G_LD next cycle regardless of state. The counter reloads green from the G_LD init pulse.

Optional Feature:
- PED_REQ_EN defined:
  - ped_req and walk ports exist.
  - ped_req high in any cycle sets ped_pend.
  - GREEN early exit: ped_pend & tick & ~hold & (pGREEN_INIT_VAL - cnt_in >= pPED_MIN_GREEN) -> Y_LD. The subtraction is done at pCNT_WIDTH+1 bits, unsigned.
  - On GREEN->Y_LD with ped_pend set, walk_arm <= 1.
  - On entry to R_LD: walk <= walk_arm, ped_pend <= 0, walk_arm <= 0.
  - walk clears on entry to G_LD.
  - A request arriving during Y_LD/YELLOW/RED stays pending for the next green.
- PED_REQ_EN undefined: ports absent, walk logic absent, behaviour exactly as above.

Test Plan:
- Reset release, tick tied high, hold=0, counter instance with defaults -> init=001 for 1 cycle; light=001 for 16 cycles, 010 for 4, 100 for 19; init pulses 010 and 100 at phase starts; 39-cycle period repeats.
- tick every 4th cycle -> dwell cycles scale accordingly; en high only on tick cycles with last=0; cnt_out never wraps to 31.
- hold=1 for 10 cycles mid-GREEN at cnt=7 -> en=0, cnt stays 7, light stays 001; resumes on release.
- hold=1 on the cycle with last=1 & tick=1 -> no transition; the next tick after release moves to Y_LD.
- rst_n=0 for 1 cycle during RED at cnt=9 -> next cycle G_LD with init=001, light=001; counter reloads 14.
- PED_REQ_EN: ped_req pulse at cnt=12 in GREEN -> no exit until cnt_in=10, then Y_LD; walk=1 through R_LD/RED, 0 at G_LD.

Source files
------------

// File: rtl/light_sequencer.sv
// Phase controller for one approach: GREEN -> YELLOW -> RED, driving the light counter's load/decrement strobes.
// Optional pedestrian early-exit and walk lamp enabled by defining PED_REQ_EN.
module light_sequencer #(
  parameter int unsigned pINIT_WIDTH     = 3,
  parameter int unsigned pCNT_WIDTH      = 5,
  parameter int unsigned pGREEN_INIT_VAL = 14,
  parameter int unsigned pPED_MIN_GREEN  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tick,
  input  logic                   hold,
  input  logic                   last,
  input  logic [pCNT_WIDTH-1:0]  cnt_in,
`ifdef PED_REQ_EN
  input  logic                   ped_req,
  output logic                   walk,
`endif
  output logic [pINIT_WIDTH-1:0] init,
  output logic                   en,
  output logic [2:0]             light
);

  localparam int unsigned EW = pCNT_WIDTH + 1;

  typedef enum logic [2:0] {
    G_LD   = 3'd0,
    GREEN  = 3'd1,
    Y_LD   = 3'd2,
    YELLOW = 3'd3,
    R_LD   = 3'd4,
    RED    = 3'd5
  } state_t;

  state_t state, state_next;
  logic   adv;
  logic   ped_exit;

  assign adv = tick & last & ~hold;

`ifdef PED_REQ_EN
  logic          ped_pend;
  logic          walk_arm;
  logic [EW-1:0] elapsed;

  // Elapsed green ticks, computed one bit wider so a stale count cannot alias
  assign elapsed  = EW'(pGREEN_INIT_VAL) - {1'b0, cnt_in};
  assign ped_exit = ped_pend & tick & ~hold & (elapsed >= EW'(pPED_MIN_GREEN));
`else
  logic unused_cfg;
  assign unused_cfg = ^{cnt_in, 32'(pGREEN_INIT_VAL), 32'(pPED_MIN_GREEN), EW};
  assign ped_exit   = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= G_LD;
    else        state <= state_next;
  end

  // Next state and Moore decodes; en is the only input-dependent output
  always_comb begin
    state_next = state;
    init       = '0;
    en         = 1'b0;
    light      = 3'b001;
    unique case (state)
      G_LD: begin
        init       = pINIT_WIDTH'(3'b001);
        state_next = GREEN;
      end
      GREEN: begin
        en = tick & ~last & ~hold;
        if (adv || ped_exit) state_next = Y_LD;
      end
      Y_LD: begin
        init       = pINIT_WIDTH'(3'b010);
        light      = 3'b010;
        state_next = YELLOW;
      end
      YELLOW: begin
        light = 3'b010;
        en    = tick & ~last & ~hold;
        if (adv) state_next = R_LD;
      end
      R_LD: begin
        init       = pINIT_WIDTH'(3'b100);
        light      = 3'b100;
        state_next = RED;
      end
      RED: begin
        light = 3'b100;
        en    = tick & ~last & ~hold;
        if (adv) state_next = G_LD;
      end
      default: state_next = G_LD;
    endcase
  end

`ifdef PED_REQ_EN
  // Pending request survives until the red phase that follows its walk is entered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      walk     <= 1'b0;
      ped_pend <= 1'b0;
      walk_arm <= 1'b0;
    end else begin
      if (state == GREEN && state_next == Y_LD && ped_pend) walk_arm <= 1'b1;
      if (state != R_LD && state_next == R_LD) begin
        walk     <= walk_arm;
        ped_pend <= ped_req;
        walk_arm <= 1'b0;
      end else begin
        ped_pend <= ped_pend | ped_req;
        if (state != G_LD && state_next == G_LD) walk <= 1'b0;
      end
    end
  end
`endif

endmodule
